dist_ctrl: RTL

DIST_CTRL -- requirements
Module: dist_ctrl

---
 rtl/dist_pkg.sv | 30 +++
 rtl/cfg_fifo.sv | 57 +++++
 rtl/dist_ctrl.sv | 131 +++++++++++++
 3 files changed

// File: rtl/dist_pkg.sv
// dist_pkg -- shared FSM state type and width helpers for the crossbar distribution controller.
// Rev 1.0
`default_nettype none

package dist_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOAD   = 2'd1,
    S_STREAM = 2'd2,
    S_DRAIN  = 2'd3
  } state_t;

  localparam int NUM_PES_DEF  = 64;
  localparam int LOG2_PES_DEF = 6;
  localparam int LEN_W_DEF    = 8;
  localparam int SEL_W        = NUM_PES_DEF * LOG2_PES_DEF;
  localparam int CFG_W        = SEL_W + LEN_W_DEF;

  function automatic int sel_width(input int num_pes, input int log2_pes);
    return num_pes * log2_pes;
  endfunction

  function automatic int cfg_width(input int num_pes, input int log2_pes, input int len_w);
    return num_pes * log2_pes + len_w;
  endfunction

endpackage

`default_nettype wire

// File: rtl/cfg_fifo.sv
// cfg_fifo -- power-of-two config FIFO; ready depends only on registered occupancy.
// Rev 1.0
`default_nettype none

module cfg_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push_valid,
  output logic             o_push_ready,
  input  logic [WIDTH-1:0] i_push_data,
  input  logic             i_pop,
  output logic             o_empty,
  output logic [WIDTH-1:0] o_pop_data
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             push;
  logic             pop;

  // A pop in the same cycle never frees a slot for a push.
  assign o_push_ready = (count != FULL_CNT);
  assign o_empty      = (count == '0);
  assign push         = i_push_valid && o_push_ready;
  assign pop          = i_pop && !o_empty;
  assign o_pop_data   = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      if (push && !pop)      count <= count + CNT_ONE;
      else if (pop && !push) count <= count - CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= i_push_data;
  end

endmodule

`default_nettype wire

// File: rtl/dist_ctrl.sv
// dist_ctrl -- sequences queued crossbar select configs over counted data beats.
// Rev 1.0; define DIST_CTRL_STATS_EN to add beat/stall statistics outputs.
`default_nettype none

module dist_ctrl
  import dist_pkg::*;
#(
  parameter int NUM_PES   = 64,
  parameter int LOG2_PES  = 6,
  parameter int LEN_W     = 8,
  parameter int CFG_DEPTH = 4
) (
  input  logic                         CLK,
  input  logic                         rst,
  input  logic                         i_cfg_valid,
  output logic                         o_cfg_ready,
  input  logic [LOG2_PES*NUM_PES-1:0]  i_cfg_sel,
  input  logic [LEN_W-1:0]             i_cfg_len,
  input  logic                         i_data_valid,
  output logic                         o_data_ready,
  input  logic                         i_stall,
  output logic [LOG2_PES*NUM_PES-1:0]  o_mux_bus,
  output logic                         o_dist_valid,
  output logic                         o_busy,
  output logic                         o_done
`ifdef DIST_CTRL_STATS_EN
  ,
  output logic [31:0]                  o_beat_cnt,
  output logic [31:0]                  o_stall_cnt
`endif
);

  localparam int SW = sel_width(NUM_PES, LOG2_PES);
  localparam int CW = cfg_width(NUM_PES, LOG2_PES, LEN_W);
  localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

  state_t          state;
  logic [LEN_W-1:0] cnt;
  logic [SW-1:0]    pend_sel;
  logic [LEN_W-1:0] pend_len;
  logic [CW-1:0]    head;
  logic             fifo_empty;
  logic             pop;
  logic             fire;

  assign pop          = (state == S_IDLE) && !fifo_empty;
  assign o_data_ready = (state == S_STREAM) && !i_stall;
  assign fire         = o_data_ready && i_data_valid;

  cfg_fifo #(
    .WIDTH (CW),
    .DEPTH (CFG_DEPTH)
  ) u_cfg_fifo (
    .clk          (CLK),
    .rst          (rst),
    .i_push_valid (i_cfg_valid),
    .o_push_ready (o_cfg_ready),
    .i_push_data  ({i_cfg_sel, i_cfg_len}),
    .i_pop        (pop),
    .o_empty      (fifo_empty),
    .o_pop_data   (head)
  );

  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      cnt          <= '0;
      pend_sel     <= '0;
      pend_len     <= '0;
      o_mux_bus    <= '0;
      o_dist_valid <= 1'b0;
      o_done       <= 1'b0;
      o_busy       <= 1'b0;
    end else begin
      // Mirrors the crossbar's own output register: valid one cycle after fire.
      o_dist_valid <= fire;
      o_done       <= 1'b0;
      case (state)
        S_IDLE: begin
          if (!fifo_empty) begin
            {pend_sel, pend_len} <= head;
            state  <= S_LOAD;
            o_busy <= 1'b1;
          end
        end
        S_LOAD: begin
          o_mux_bus <= pend_sel;
          cnt       <= pend_len;
          if (pend_len != '0) begin
            state <= S_STREAM;
          end else begin
            state  <= S_DRAIN;
            o_done <= 1'b1;
          end
        end
        S_STREAM: begin
          if (fire) begin
            cnt <= cnt - LEN_ONE;
            if (cnt == LEN_ONE) begin
              state  <= S_DRAIN;
              o_done <= 1'b1;
            end
          end
        end
        S_DRAIN: begin
          state  <= S_IDLE;
          o_busy <= 1'b0;
        end
        default: begin
          state  <= S_IDLE;
          o_busy <= 1'b0;
        end
      endcase
    end
  end

`ifdef DIST_CTRL_STATS_EN
  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      o_beat_cnt  <= '0;
      o_stall_cnt <= '0;
    end else begin
      if (fire) o_beat_cnt <= o_beat_cnt + 32'd1;
      if ((state == S_STREAM) && i_data_valid && i_stall) o_stall_cnt <= o_stall_cnt + 32'd1;
    end
  end
`endif

endmodule

`default_nettype wire
